// File: rtl/skin_mask_stream_if.sv
// rtl/skin_mask_stream_if.sv - pixel input stream between a pixel source and skin_mask_stream
interface skin_mask_stream_if #(
  parameter int COLOR_DEPTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sof;
  logic [COLOR_DEPTH-1:0] in_r;
  logic [COLOR_DEPTH-1:0] in_g;
  logic [COLOR_DEPTH-1:0] in_b;

  modport master (output in_valid, in_sof, in_r, in_g, in_b, input in_ready);
  modport slave  (input in_valid, in_sof, in_r, in_g, in_b, output in_ready);
endinterface

// File: rtl/skin_mask_stream.sv
// rtl/skin_mask_stream.sv - streaming skin mask with per-frame count, centroid and bounding box
// The mask leaves one cycle after acceptance; the centroid comes from two bit-serial restoring dividers.
module skin_mask_stream #(
  parameter int WIDTH       = 256,
  parameter int DEPTH       = 256,
  parameter int COLOR_DEPTH = 8,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(DEPTH),
  localparam int CW = $clog2(WIDTH * DEPTH + 1),
  localparam int QW = (XW > YW) ? XW : YW,
  localparam int SW = QW + CW,
  localparam int DW = $clog2(SW + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  skin_mask_stream_if.slave      pix,
  input  logic [COLOR_DEPTH-1:0] u_lo,
  input  logic [COLOR_DEPTH-1:0] u_hi,
  input  logic [COLOR_DEPTH-1:0] v_lo,
  input  logic [COLOR_DEPTH-1:0] v_hi,
  input  logic                   use_v,
  output logic                   out_valid,
  output logic                   out_mask,
  output logic [COLOR_DEPTH-1:0] out_pixel,
  output logic [XW-1:0]          out_x,
  output logic [YW-1:0]          out_y,
  output logic                   stats_valid,
  output logic [CW-1:0]          pix_count,
  output logic [XW-1:0]          centroid_x,
  output logic [YW-1:0]          centroid_y,
  output logic [XW-1:0]          bbox_x0,
  output logic [YW-1:0]          bbox_y0,
  output logic [XW-1:0]          bbox_x1,
  output logic [YW-1:0]          bbox_y1,
  output logic                   no_face
);
  typedef enum logic [1:0] {ACCEPT, DIVIDE, REPORT} state_e;

  state_e                 state_q;
  logic                   ready_q, usev_q;
  logic [XW-1:0]          x_q, minx_q, maxx_q, qx_q;
  logic [YW-1:0]          y_q, miny_q, maxy_q, qy_q;
  logic [COLOR_DEPTH-1:0] ulo_q, uhi_q, vlo_q, vhi_q;
  logic [CW-1:0]          cnt_q, den_q, rx_q, ry_q;
  logic [SW-1:0]          sx_q, sy_q, nx_q, ny_q;
  logic [DW-1:0]          dcnt_q;
  logic                   ov_q, om_q, sv_q, nf_q;
  logic [XW-1:0]          ox_q, cx_q, bx0_q, bx1_q;
  logic [YW-1:0]          oy_q, cy_q, by0_q, by1_q;
  logic [CW-1:0]          pc_q;

  logic                   accept, at_origin, line_end, frame_end, skin, t_usev, bx, by;
  logic [XW-1:0]          cur_x, minx_d, maxx_d;
  logic [YW-1:0]          cur_y, miny_d, maxy_d;
  logic [COLOR_DEPTH-1:0] t_ulo, t_uhi, t_vlo, t_vhi, u_c, v_c;
  logic [CW-1:0]          cnt_d, rx_d, ry_d;
  logic [SW-1:0]          sx_d, sy_d;
  logic [CW:0]            rx_sh, ry_sh;

  always_comb begin
    accept    = pix.in_valid && ready_q;
    cur_x     = pix.in_sof ? '0 : x_q;
    cur_y     = pix.in_sof ? '0 : y_q;
    at_origin = (cur_x == '0) && (cur_y == '0);
    line_end  = cur_x == XW'(WIDTH - 1);
    frame_end = line_end && (cur_y == YW'(DEPTH - 1));
    // The first pixel of a frame is classified with the live thresholds it is about to latch
    t_ulo  = at_origin ? u_lo  : ulo_q;
    t_uhi  = at_origin ? u_hi  : uhi_q;
    t_vlo  = at_origin ? v_lo  : vlo_q;
    t_vhi  = at_origin ? v_hi  : vhi_q;
    t_usev = at_origin ? use_v : usev_q;
    u_c  = (pix.in_r >= pix.in_g) ? pix.in_r - pix.in_g : '0;
    v_c  = (pix.in_b >= pix.in_g) ? pix.in_b - pix.in_g : '0;
    skin = (t_ulo < u_c) && (u_c < t_uhi) && (!t_usev || ((t_vlo < v_c) && (v_c < t_vhi)));
    cnt_d  = pix.in_sof ? '0 : cnt_q;
    sx_d   = pix.in_sof ? '0 : sx_q;
    sy_d   = pix.in_sof ? '0 : sy_q;
    minx_d = pix.in_sof ? '1 : minx_q;
    maxx_d = pix.in_sof ? '0 : maxx_q;
    miny_d = pix.in_sof ? '1 : miny_q;
    maxy_d = pix.in_sof ? '0 : maxy_q;
    if (skin) begin
      cnt_d = cnt_d + CW'(1);
      sx_d  = sx_d + SW'(cur_x);
      sy_d  = sy_d + SW'(cur_y);
      if (cur_x < minx_d) minx_d = cur_x;
      if (cur_x > maxx_d) maxx_d = cur_x;
      if (cur_y < miny_d) miny_d = cur_y;
      if (cur_y > maxy_d) maxy_d = cur_y;
    end
    rx_sh = {rx_q, nx_q[SW-1]};
    ry_sh = {ry_q, ny_q[SW-1]};
    bx    = rx_sh >= {1'b0, den_q};
    by    = ry_sh >= {1'b0, den_q};
    rx_d  = bx ? CW'(rx_sh - {1'b0, den_q}) : rx_sh[CW-1:0];
    ry_d  = by ? CW'(ry_sh - {1'b0, den_q}) : ry_sh[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      ready_q <= 1'b1;
      x_q <= '0;  y_q <= '0;
      ulo_q <= '0;  uhi_q <= '0;  vlo_q <= '0;  vhi_q <= '0;  usev_q <= 1'b0;
      cnt_q <= '0;  sx_q <= '0;  sy_q <= '0;
      minx_q <= '1;  maxx_q <= '0;  miny_q <= '1;  maxy_q <= '0;
      nx_q <= '0;  ny_q <= '0;  den_q <= '0;  rx_q <= '0;  ry_q <= '0;
      qx_q <= '0;  qy_q <= '0;  dcnt_q <= '0;
      ov_q <= 1'b0;  om_q <= 1'b0;  ox_q <= '0;  oy_q <= '0;
      sv_q <= 1'b0;  pc_q <= '0;  cx_q <= '0;  cy_q <= '0;  nf_q <= 1'b0;
      bx0_q <= '0;  by0_q <= '0;  bx1_q <= '0;  by1_q <= '0;
    end else begin
      ov_q <= accept;
      sv_q <= 1'b0;
      if (accept) begin
        om_q <= skin;
        ox_q <= cur_x;
        oy_q <= cur_y;
      end
      case (state_q)
        ACCEPT: if (accept) begin
          cnt_q <= cnt_d;  sx_q <= sx_d;  sy_q <= sy_d;
          minx_q <= minx_d;  maxx_q <= maxx_d;  miny_q <= miny_d;  maxy_q <= maxy_d;
          x_q <= line_end ? '0 : cur_x + XW'(1);
          y_q <= !line_end ? cur_y : (frame_end ? '0 : cur_y + YW'(1));
          if (at_origin) begin
            ulo_q <= u_lo;  uhi_q <= u_hi;  vlo_q <= v_lo;  vhi_q <= v_hi;  usev_q <= use_v;
          end
          if (frame_end) begin
            ready_q <= 1'b0;
            nx_q <= sx_d;  ny_q <= sy_d;  den_q <= cnt_d;
            rx_q <= '0;  ry_q <= '0;  qx_q <= '0;  qy_q <= '0;  dcnt_q <= '0;
            if (cnt_d == '0) begin
              state_q <= REPORT;
              sv_q <= 1'b1;  nf_q <= 1'b1;  pc_q <= '0;  cx_q <= '0;  cy_q <= '0;
              bx0_q <= '0;  by0_q <= '0;  bx1_q <= '0;  by1_q <= '0;
            end else begin
              state_q <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          nx_q <= nx_q << 1;  ny_q <= ny_q << 1;
          rx_q <= rx_d;  ry_q <= ry_d;
          // Only the low quotient bits survive; the centroid never exceeds the frame size
          qx_q <= XW'({qx_q, bx});
          qy_q <= YW'({qy_q, by});
          dcnt_q <= dcnt_q + DW'(1);
          if (dcnt_q == DW'(SW - 1)) begin
            state_q <= REPORT;
            sv_q <= 1'b1;  nf_q <= 1'b0;  pc_q <= den_q;
            cx_q <= XW'({qx_q, bx});  cy_q <= YW'({qy_q, by});
            bx0_q <= minx_q;  by0_q <= miny_q;  bx1_q <= maxx_q;  by1_q <= maxy_q;
          end
        end
        REPORT: begin
          cnt_q <= '0;  sx_q <= '0;  sy_q <= '0;
          minx_q <= '1;  maxx_q <= '0;  miny_q <= '1;  maxy_q <= '0;
          x_q <= '0;  y_q <= '0;
          ready_q <= 1'b1;
          state_q <= ACCEPT;
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  assign pix.in_ready  = ready_q;
  assign out_valid     = ov_q;
  assign out_mask      = om_q;
  assign out_pixel     = {COLOR_DEPTH{om_q}};
  assign out_x         = ox_q;
  assign out_y         = oy_q;
  assign stats_valid   = sv_q;
  assign pix_count     = pc_q;
  assign centroid_x    = cx_q;
  assign centroid_y    = cy_q;
  assign bbox_x0       = bx0_q;
  assign bbox_y0       = by0_q;
  assign bbox_x1       = bx1_q;
  assign bbox_y1       = by1_q;
  assign no_face       = nf_q;
endmodule

// File: tb/tb_skin_mask_stream.sv
// tb/tb_skin_mask_stream.sv - randomized self-checking bench for skin_mask_stream
module tb_skin_mask_stream;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CD = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(D);
  localparam int CW = $clog2(W * D + 1);
  localparam int SW = ((XW > YW) ? XW : YW) + CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CD-1:0] u_lo, u_hi, v_lo, v_hi;
  logic          use_v;
  logic          out_valid, out_mask, stats_valid, no_face;
  logic [CD-1:0] out_pixel;
  logic [XW-1:0] out_x, centroid_x, bbox_x0, bbox_x1;
  logic [YW-1:0] out_y, centroid_y, bbox_y0, bbox_y1;
  logic [CW-1:0] pix_count;

  skin_mask_stream_if #(.COLOR_DEPTH(CD)) pix_if ();

  skin_mask_stream #(.WIDTH(W), .DEPTH(D), .COLOR_DEPTH(CD)) dut (
    .clk(clk), .rst_n(rst_n), .pix(pix_if),
    .u_lo(u_lo), .u_hi(u_hi), .v_lo(v_lo), .v_hi(v_hi), .use_v(use_v),
    .out_valid(out_valid), .out_mask(out_mask), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .stats_valid(stats_valid), .pix_count(pix_count),
    .centroid_x(centroid_x), .centroid_y(centroid_y),
    .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1),
    .no_face(no_face)
  );

  int n_checks = 0;
  int n_errors = 0;
  int bubble_pct = 25;

  // Reference model state: what the design should show after the most recent clock edge
  bit e_ready, e_ov, e_mask, e_sv, e_nf, e_rst, m_acc;
  int e_x, e_y, e_cnt, e_cx, e_cy, e_x0, e_y0, e_x1, e_y1;
  int p_cnt, p_cx, p_cy, p_x0, p_y0, p_x1, p_y1;
  int busy, mx, my;
  int lt_ulo, lt_uhi, lt_vlo, lt_vhi;
  bit lt_usev;
  int sk_x[$];
  int sk_y[$];

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic frame_stats();
    int sx, sy;
    sx = 0; sy = 0;
    p_cnt = sk_x.size();
    p_x0 = W; p_y0 = D; p_x1 = -1; p_y1 = -1;
    foreach (sk_x[i]) begin
      sx += sk_x[i]; sy += sk_y[i];
      if (sk_x[i] < p_x0) p_x0 = sk_x[i];
      if (sk_x[i] > p_x1) p_x1 = sk_x[i];
      if (sk_y[i] < p_y0) p_y0 = sk_y[i];
      if (sk_y[i] > p_y1) p_y1 = sk_y[i];
    end
    if (p_cnt == 0) begin
      p_cx = 0; p_cy = 0; p_x0 = 0; p_y0 = 0; p_x1 = 0; p_y1 = 0;
    end else begin
      p_cx = sx / p_cnt; p_cy = sy / p_cnt;
    end
    sk_x.delete(); sk_y.delete();
  endtask

  task automatic publish();
    e_sv = 1; e_cnt = p_cnt; e_cx = p_cx; e_cy = p_cy;
    e_x0 = p_x0; e_y0 = p_y0; e_x1 = p_x1; e_y1 = p_y1; e_nf = (p_cnt == 0);
  endtask

  task automatic predict();
    e_rst = !rst_n;
    m_acc = 0;
    if (!rst_n) begin
      e_ready = 1; e_ov = 0; e_mask = 0; e_x = 0; e_y = 0; e_sv = 0; e_nf = 0;
      e_cnt = 0; e_cx = 0; e_cy = 0; e_x0 = 0; e_y0 = 0; e_x1 = 0; e_y1 = 0;
      busy = 0; mx = 0; my = 0; sk_x.delete(); sk_y.delete();
    end else begin
      e_sv = 0;
      m_acc = pix_if.in_valid && e_ready;
      if (busy > 0) begin
        busy--;
        if (busy == 1) publish();
        if (busy == 0) e_ready = 1;
      end
      e_ov = m_acc;
      if (m_acc) begin
        int u, v;
        bit skin;
        if (pix_if.in_sof) begin
          mx = 0; my = 0; sk_x.delete(); sk_y.delete();
        end
        if (mx == 0 && my == 0) begin
          lt_ulo = u_lo; lt_uhi = u_hi; lt_vlo = v_lo; lt_vhi = v_hi; lt_usev = use_v;
        end
        u = (pix_if.in_r >= pix_if.in_g) ? int'(pix_if.in_r) - int'(pix_if.in_g) : 0;
        v = (pix_if.in_b >= pix_if.in_g) ? int'(pix_if.in_b) - int'(pix_if.in_g) : 0;
        skin = (lt_ulo < u) && (u < lt_uhi) && (!lt_usev || (lt_vlo < v && v < lt_vhi));
        e_mask = skin; e_x = mx; e_y = my;
        if (skin) begin
          sk_x.push_back(mx); sk_y.push_back(my);
        end
        if (mx == W - 1 && my == D - 1) begin
          frame_stats();
          e_ready = 0;
          busy = (p_cnt > 0) ? SW + 1 : 1;
          if (busy == 1) publish();
          mx = 0; my = 0;
        end else if (mx == W - 1) begin
          mx = 0; my++;
        end else begin
          mx++;
        end
      end
    end
  endtask

  task automatic compare();
    expect_eq("in_ready", pix_if.in_ready, e_ready);
    expect_eq("out_valid", out_valid, e_ov);
    if (e_ov || e_rst) begin
      expect_eq("out_mask", out_mask, e_mask);
      expect_eq("out_pixel", out_pixel, e_mask ? 255 : 0);
      expect_eq("out_x", out_x, e_x);
      expect_eq("out_y", out_y, e_y);
    end
    expect_eq("stats_valid", stats_valid, e_sv);
    expect_eq("pix_count", pix_count, e_cnt);
    expect_eq("centroid_x", centroid_x, e_cx);
    expect_eq("centroid_y", centroid_y, e_cy);
    expect_eq("bbox_x0", bbox_x0, e_x0);
    expect_eq("bbox_y0", bbox_y0, e_y0);
    expect_eq("bbox_x1", bbox_x1, e_x1);
    expect_eq("bbox_y1", bbox_y1, e_y1);
    expect_eq("no_face", no_face, e_nf);
  endtask

  task automatic tick();
    predict();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    pix_if.in_valid = 0; pix_if.in_sof = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int r, input int g, input int b, input bit sof);
    int guard;
    guard = 0;
    do begin
      pix_if.in_valid = ($urandom_range(0, 99) >= bubble_pct);
      pix_if.in_r = CD'(r); pix_if.in_g = CD'(g); pix_if.in_b = CD'(b);
      pix_if.in_sof = sof;
      tick();
      guard++;
      if (!m_acc && guard > 100) begin
        n_checks++; n_errors++;
        $display("FAIL send_timeout: pixel not accepted after %0d cycles", guard);
        break;
      end
    end while (!m_acc);
    pix_if.in_valid = 0; pix_if.in_sof = 0;
  endtask

  task automatic rand_thresh();
    u_lo = CD'($urandom_range(0, 40));  u_hi = u_lo + CD'($urandom_range(2, 90));
    v_lo = CD'($urandom_range(0, 20));  v_hi = v_lo + CD'($urandom_range(2, 60));
    use_v = 1'($urandom_range(0, 1));
  endtask

  task automatic gen(input int kind, input int x, input int y, output int r, output int g, output int b);
    if (kind == 1) begin
      r = 0; g = 0; b = 0;
    end else if (kind == 2) begin
      if ((x == 2 && y == 1) || (x == 5 && y == 1) || (x == 2 && y == 6)) begin
        r = 150; g = 100; b = 100;
      end else begin
        r = 0; g = 0; b = 0;
      end
    end else begin
      g = $urandom_range(0, 150);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, g) : g + $urandom_range(0, 100);
      b = g + $urandom_range(0, 60);
    end
  endtask

  // Sends raster indices first..last-1; random frames also scramble thresholds mid-frame
  task automatic send_frame(input int kind, input int first, input int last, input bit sof_first);
    int r, g, b;
    for (int i = first; i < last; i++) begin
      gen(kind, i % W, i / W, r, g, b);
      if (kind == 0 && i != first && $urandom_range(0, 19) == 0) rand_thresh();
      send(r, g, b, sof_first && (i == first));
    end
  endtask

  task automatic stats_latency(input string tag, input int exp);
    int lat;
    lat = 1;
    while (!stats_valid && lat < SW + 6) begin
      idle(1);
      lat++;
    end
    expect_eq(tag, lat, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ub_r[5] = '{126, 127, 173, 174, 50};
    int ub_m[5] = '{0, 1, 1, 0, 0};
    rst_n = 0;
    pix_if.in_valid = 0; pix_if.in_sof = 0; pix_if.in_r = 0; pix_if.in_g = 0; pix_if.in_b = 0;
    u_lo = 26; u_hi = 74; v_lo = 10; v_hi = 50; use_v = 0;
    idle(3);
    rst_n = 1;
    idle(2);

    // U-window boundaries and saturation at the start of a frame
    for (int i = 0; i < 5; i++) begin
      send(ub_r[i], 100, 0, 0);
      expect_eq("u_boundary_mask", out_mask, ub_m[i]);
    end
    send_frame(0, 5, W * D, 0);

    // V mode; threshold changes mid-frame must not take effect
    idle(SW + 2);
    u_lo = 26; u_hi = 74; v_lo = 10; v_hi = 50; use_v = 1;
    send(150, 100, 110, 0);
    expect_eq("v_edge_mask", out_mask, 0);
    send(150, 100, 130, 0);
    expect_eq("v_inside_mask", out_mask, 1);
    u_lo = 200; u_hi = 210; use_v = 0;
    send_frame(0, 2, W * D, 0);

    // Centroid frame
    idle(SW + 2);
    u_lo = 26; u_hi = 74; use_v = 0;
    send_frame(2, 0, W * D, 0);
    stats_latency("centroid_latency", SW + 1);
    expect_eq("centroid_count", pix_count, 3);
    expect_eq("centroid_cx", centroid_x, 3);
    expect_eq("centroid_cy", centroid_y, 2);
    expect_eq("centroid_bx0", bbox_x0, 2);
    expect_eq("centroid_by0", bbox_y0, 1);
    expect_eq("centroid_bx1", bbox_x1, 5);
    expect_eq("centroid_by1", bbox_y1, 6);
    expect_eq("centroid_noface", no_face, 0);

    // Empty frame
    idle(2);
    send_frame(1, 0, W * D, 0);
    stats_latency("empty_latency", 1);
    expect_eq("empty_count", pix_count, 0);
    expect_eq("empty_noface", no_face, 1);
    expect_eq("empty_cx", centroid_x, 0);
    expect_eq("empty_bx1", bbox_x1, 0);

    // Back-to-back random frames with bubbles across frame boundaries
    bubble_pct = 35;
    for (int f = 0; f < 5; f++) begin
      rand_thresh();
      send_frame(0, 0, W * D, 0);
    end

    // Resync: partial frame abandoned by in_sof at pixel 20
    rand_thresh();
    send_frame(0, 0, 20, 0);
    rand_thresh();
    send_frame(0, 0, W * D, 1);
    idle(SW + 3);

    // Reset while dividing
    u_lo = 26; u_hi = 74; use_v = 0;
    send_frame(2, 0, W * D, 0);
    idle(3);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(SW + 4);

    // Recovery after reset
    rand_thresh();
    send_frame(0, 0, W * D, 0);
    idle(SW + 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
